uart_rx: RTL

- 8N1 asynchronous serial receiver: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity.
- Companion to the team's UART transmitter; shares its bit-timing parameter, so one CLK_PER_HALF_BIT value pairs both ends at the same baud.
- Sits between the board RXD pin and the core's byte-consuming logic (loader / MMIO input); delivers one byte per frame with a single-cycle valid strobe.

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_rx_if.sv | 10 +
 rtl/uart_sync2.sv | 31 +++
 rtl/uart_rx.sv | 131 +++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and frame constants (receiver now, transmitter later)
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;

  localparam int FRAME_BITS = 8;
  localparam int STOP_BITS  = 1;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - received-byte interface: byte, strobes and busy flag
interface uart_rx_if;
  logic [7:0] rdata;
  logic       rx_ready;
  logic       ferr;
  logic       rx_busy;

  modport master (output rdata, rx_ready, ferr, rx_busy);
  modport slave  (input  rdata, rx_ready, ferr, rx_busy);
endinterface

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - 2-flop synchronizer with configurable reset value
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_q <= RESET_VAL;
      s2_q <= RESET_VAL;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver; UART_RX_MAJORITY_EN selects 2-of-3 sampling per bit
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_PER_HALF_BIT = 5208
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      rxd,
  uart_rx_if.master rx_if
);

  logic rxd_s;
  logic sample;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (rxd),
    .q       (rxd_s)
  );

`ifdef UART_RX_MAJORITY_EN
  // Decision lands one cycle after the nominal point so the sample after it is available.
  localparam int SAMPLE_OFS = 1;
  logic [1:0] hist_q, hist_d;

  always_comb hist_d = {hist_q[0], rxd_s};

  always_ff @(posedge clk) begin
    if (!reset_n) hist_q <= 2'b11;
    else          hist_q <= hist_d;
  end

  assign sample = maj3(hist_q[1], hist_q[0], rxd_s);
`else
  localparam int SAMPLE_OFS = 0;
  assign sample = rxd_s;
`endif

  localparam logic [31:0] HALF_T = 32'(CLK_PER_HALF_BIT - 1 + SAMPLE_OFS);
  localparam logic [31:0] FULL_T = 32'(2 * CLK_PER_HALF_BIT - 1 + SAMPLE_OFS);

  rx_state_e   state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        rx_ready_q, rx_ready_d;
  logic        ferr_q, ferr_d;
  logic        prev_q, prev_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 32'd1;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    rdata_d    = rdata_q;
    rx_ready_d = 1'b0;
    ferr_d     = 1'b0;
    prev_d     = rxd_s;
    case (state_q)
      IDLE: begin
        if (!rxd_s && prev_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_T) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = sample ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == FULL_T) begin
          cnt_d     = '0;
          shift_d   = {sample, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'(FRAME_BITS - 1)) state_d = STOP;
        end
      end
      STOP: begin
        // Leaving at mid stop bit keeps half a bit to catch a back-to-back start edge.
        if (cnt_q == FULL_T) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (sample) begin
            rdata_d    = shift_q;
            rx_ready_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      rdata_q    <= '0;
      rx_ready_q <= 1'b0;
      ferr_q     <= 1'b0;
      prev_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      rdata_q    <= rdata_d;
      rx_ready_q <= rx_ready_d;
      ferr_q     <= ferr_d;
      prev_q     <= prev_d;
    end
  end

  assign rx_if.rdata    = rdata_q;
  assign rx_if.rx_ready = rx_ready_q;
  assign rx_if.ferr     = ferr_q;
  assign rx_if.rx_busy  = (state_q != IDLE);

endmodule
